fp_add_issuer: RTL and testbench



---
 rtl/fp_issue_pkg.sv | 29 ++
 rtl/req_fifo.sv | 42 ++++
 rtl/fp_add_issuer.sv | 131 +++++++++++++
 tb/tb_fp_add_issuer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_issue_pkg.sv
// rtl/fp_issue_pkg.sv - shared types and constants for the FP32 adder issuer
package fp_issue_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } issue_state_t;

  localparam logic [31:0] FP32_QNAN     = 32'h7FC0_0000;
  localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;
  localparam int          REQ_TAG_W     = 4;

  typedef struct packed {
    logic [31:0]          a;
    logic [31:0]          b;
    logic                 sub;
    logic [REQ_TAG_W-1:0] tag;
  } req_t;

  // Negating either zero must yield +0: the adder's zero shortcut only recognises +0.
  function automatic logic [31:0] sub_adjust(input logic [31:0] b, input logic sub);
    if (!sub) return b;
    if (b[30:0] == 31'd0) return FP32_POS_ZERO;
    return {~b[31], b[30:0]};
  endfunction

endpackage

// File: rtl/req_fifo.sv
// rtl/req_fifo.sv - in-order request FIFO, wrap-bit pointers, combinational head read
module req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 69
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int           AW      = $clog2(DEPTH);
  localparam logic [AW:0]  PTR_ONE = (AW+1)'(1);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q;
  logic [AW:0]  rd_ptr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/fp_add_issuer.sv
// rtl/fp_add_issuer.sv - queues FP32 add/sub requests, drives one adder, returns tagged results
module fp_add_issuer
  import fp_issue_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_timeout,
  output logic [31:0]      fpu_a,
  output logic [31:0]      fpu_b,
  output logic             fpu_en,
  input  logic [31:0]      fpu_sum,
  input  logic             fpu_ready,
  output logic             busy
);

  localparam int              WD_W    = $clog2(TIMEOUT);
  localparam int              REQ_W   = 65 + TAG_W;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

  issue_state_t     state_q, state_d;
  logic             fifo_full, fifo_empty, pop;
  logic [REQ_W-1:0] head;
  logic [31:0]      head_a, head_b;
  logic             head_sub;
  logic [TAG_W-1:0] head_tag;
  logic [WD_W-1:0]  wd_q;
  logic             wd_expired;
  logic [31:0]      fpu_a_q, fpu_b_q, out_sum_q;
  logic [TAG_W-1:0] out_tag_q;
  logic             out_timeout_q;

  req_fifo #(.DEPTH(DEPTH), .W(REQ_W)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (in_valid && !fifo_full),
    .wdata_i ({in_a, in_b, in_sub, in_tag}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign {head_a, head_b, head_sub, head_tag} = head;
  assign wd_expired = (wd_q == WD_LAST);

  // Pop on entry to ISSUE so operands are already on fpu_a/fpu_b while fpu_en is high.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d = ST_ISSUE;
          pop     = 1'b1;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (fpu_ready || wd_expired) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (out_ready) begin
          if (!fifo_empty) begin
            state_d = ST_ISSUE;
            pop     = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      wd_q          <= '0;
      fpu_a_q       <= '0;
      fpu_b_q       <= '0;
      out_sum_q     <= '0;
      out_tag_q     <= '0;
      out_timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        fpu_a_q   <= head_a;
        fpu_b_q   <= sub_adjust(head_b, head_sub);
        out_tag_q <= head_tag;
      end
      if (state_q == ST_ISSUE)     wd_q <= '0;
      else if (state_q == ST_WAIT) wd_q <= wd_q + WD_ONE;
      // A real completion wins over a watchdog expiry landing on the same cycle.
      if (state_q == ST_WAIT) begin
        if (fpu_ready) begin
          out_sum_q     <= fpu_sum;
          out_timeout_q <= 1'b0;
        end else if (wd_expired) begin
          out_sum_q     <= FP32_QNAN;
          out_timeout_q <= 1'b1;
        end
      end
    end
  end

  assign in_ready    = !fifo_full;
  assign out_valid   = (state_q == ST_RESP);
  assign out_sum     = out_sum_q;
  assign out_tag     = out_tag_q;
  assign out_timeout = out_timeout_q;
  assign fpu_a       = fpu_a_q;
  assign fpu_b       = fpu_b_q;
  assign fpu_en      = (state_q == ST_ISSUE);
  assign busy        = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_fp_add_issuer.sv
// tb/tb_fp_add_issuer.sv - directed and randomised checks of fp_add_issuer against a stand-in adder
module tb_fp_add_issuer;

  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 32;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_a = '0, in_b = '0;
  logic             in_sub = 1'b0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_sum;
  logic [TAG_W-1:0] out_tag;
  logic             out_timeout;
  logic [31:0]      fpu_a, fpu_b, fpu_sum;
  logic             fpu_en, fpu_ready, busy;

  logic             model_rdy = 1'b0, stray_rdy = 1'b0;
  logic [31:0]      model_sum = '0;
  assign fpu_ready = model_rdy | stray_rdy;
  assign fpu_sum   = model_sum;

  fp_add_issuer #(.DEPTH(4), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_sub(in_sub), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_tag(out_tag), .out_timeout(out_timeout),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_en(fpu_en),
    .fpu_sum(fpu_sum), .fpu_ready(fpu_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Stand-in adder arithmetic: exact for the 1.0 + 2.0 vector, a cheap mixing function otherwise.
  function automatic logic [31:0] fmodel(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return a + b;
  endfunction

  function automatic logic [31:0] exp_b(input logic [31:0] b, input logic sub);
    if (sub && (b == 32'h0000_0000 || b == 32'h8000_0000)) return 32'h0000_0000;
    if (sub) return b ^ 32'h8000_0000;
    return b;
  endfunction

  // Adder model
  int          lat = 7;
  bit          hang = 0, rand_lat = 0, chk_b2b = 0;
  int          cnt = 0;
  bit          mbusy = 0, prev_en = 0, unstable = 0;
  logic [31:0] la = '0, lb = '0;
  int          last_en_cyc = -1, last_rdy_cyc = -1, n_en = 0, last_hs_cyc = -1;

  always @(negedge clk) begin
    model_rdy = 1'b0;
    if (!reset_n) begin
      mbusy   = 0;
      prev_en = 0;
    end else begin
      if (mbusy) begin
        if (fpu_a !== la || fpu_b !== lb) unstable = 1;
        cnt--;
        if (cnt == 0) begin
          model_rdy    = 1'b1;
          model_sum    = fmodel(la, lb);
          mbusy        = 0;
          last_rdy_cyc = cyc;
          chk("fpu_ab_stable", 32'(unstable), 32'd0);
        end
      end
      if (fpu_en) begin
        chk("en_single_pulse", 32'(prev_en), 32'd0);
        if (chk_b2b) chk("en_after_hs", cyc, last_hs_cyc + 1);
        mbusy       = !hang;
        unstable    = 0;
        la          = fpu_a;
        lb          = fpu_b;
        cnt         = rand_lat ? int'($urandom_range(1, 4)) : lat;
        last_en_cyc = cyc;
        n_en++;
      end
      prev_en = fpu_en;
    end
  end

  // Result monitor / scoreboard
  typedef struct packed {
    logic [31:0]      sum;
    logic [TAG_W-1:0] tag;
    logic             to;
  } exp_t;
  exp_t             exp_q[$];
  bit               hold = 0, prev_ov = 0;
  logic [31:0]      h_sum;
  logic [TAG_W-1:0] h_tag;
  logic             h_to;
  int               ov_cyc = -1, n_resp = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      hold    = 0;
      prev_ov = 0;
    end else begin
      if (hold) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_sum", out_sum, h_sum);
        chk("hold_tag", 32'(out_tag), 32'(h_tag));
        chk("hold_to", 32'(out_timeout), 32'(h_to));
      end
      if (out_valid && !prev_ov) ov_cyc = cyc;
      if (out_valid && out_ready) begin
        chk("resp_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("resp_sum", out_sum, e.sum);
          chk("resp_tag", 32'(out_tag), 32'(e.tag));
          chk("resp_timeout", 32'(out_timeout), 32'(e.to));
        end
        last_hs_cyc = cyc;
        n_resp++;
      end
      hold    = out_valid && !out_ready;
      h_sum   = out_sum;
      h_tag   = out_tag;
      h_to    = out_timeout;
      prev_ov = out_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int acc_cyc = -1;

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic sub,
                      input logic [TAG_W-1:0] tag);
    int n = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub; in_tag = tag;
    while (!in_ready && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) chk("push_accept", 32'(n), 32'd0);
    acc_cyc = cyc;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic exp_push(input logic [31:0] a, input logic [31:0] b, input logic sub,
                          input logic [TAG_W-1:0] tag, input logic [31:0] s, input logic to);
    exp_t e;
    e.sum = s; e.tag = tag; e.to = to;
    exp_q.push_back(e);
    push(a, b, sub, tag);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      tick();
      n++;
    end
    chk({tag, "_drain"}, 32'(n < 3000), 32'd1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_sum"}, out_sum, 32'd0);
    chk({tag, "_out_tag"}, 32'(out_tag), 32'd0);
    chk({tag, "_out_timeout"}, 32'(out_timeout), 32'd0);
    chk({tag, "_fpu_a"}, fpu_a, 32'd0);
    chk({tag, "_fpu_b"}, fpu_b, 32'd0);
    chk({tag, "_fpu_en"}, 32'(fpu_en), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #600000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n0, r0;
    bit done;
    logic [31:0] ra, rb;
    logic rs;

    reset_n = 1'b0;
    repeat (3) tick();
    check_reset("rst");
    reset_n = 1'b1;
    tick();

    // single add
    out_ready = 1'b1;
    n0 = n_en;
    exp_push(32'h3F80_0000, 32'h4000_0000, 1'b0, 4'd3, 32'h4040_0000, 1'b0);
    drain("t1");
    chk("t1_en_latency", last_en_cyc, acc_cyc + 2);
    chk("t1_one_en", n_en, n0 + 1);
    chk("t1_valid_after_rdy", ov_cyc, last_rdy_cyc + 1);
    chk("t1_fpu_a", la, 32'h3F80_0000);
    chk("t1_fpu_b", lb, 32'h4000_0000);

    // sign handling on subtract
    exp_push(32'h3F80_0000, 32'h4000_0000, 1'b1, 4'd1, fmodel(32'h3F80_0000, 32'hC000_0000), 1'b0);
    drain("t2a");
    chk("t2_sub_pos", lb, 32'hC000_0000);
    exp_push(32'h3F80_0000, 32'h0000_0000, 1'b1, 4'd2, fmodel(32'h3F80_0000, 32'h0), 1'b0);
    drain("t2b");
    chk("t2_sub_pzero", lb, 32'h0000_0000);
    exp_push(32'h3F80_0000, 32'h8000_0000, 1'b1, 4'd4, fmodel(32'h3F80_0000, 32'h0), 1'b0);
    drain("t2c");
    chk("t2_sub_nzero", lb, 32'h0000_0000);
    exp_push(32'h1234_5678, 32'h8000_0000, 1'b0, 4'd5, fmodel(32'h1234_5678, 32'h8000_0000), 1'b0);
    drain("t2d");
    chk("t2_add_nzero", lb, 32'h8000_0000);

    // fill under backpressure, then release
    out_ready = 1'b0;
    r0 = n_resp;
    for (int i = 0; i < 5; i++)
      exp_push(32'h0100_0000 * (i + 1), 32'h0000_0011 * (i + 2), 1'b0, TAG_W'(i),
               fmodel(32'h0100_0000 * (i + 1), 32'h0000_0011 * (i + 2)), 1'b0);
    chk("t3_full_in_ready", 32'(in_ready), 32'd0);
    chk("t3_busy", 32'(busy), 32'd1);
    chk_b2b = 1;
    out_ready = 1'b1;
    drain("t3");
    chk_b2b = 0;
    chk("t3_resp_count", n_resp, r0 + 5);

    // watchdog abort and stray completion
    hang = 1;
    exp_push(32'hAAAA_0000, 32'h0000_5555, 1'b0, 4'd7, QNAN, 1'b1);
    drain("t4");
    chk("t4_abort_cycle", ov_cyc, last_en_cyc + TIMEOUT + 1);
    hang = 0;
    r0 = n_resp;
    repeat (5) tick();
    stray_rdy = 1'b1;
    tick();
    stray_rdy = 1'b0;
    repeat (5) tick();
    chk("t4_stray_ignored_busy", 32'(busy), 32'd0);
    chk("t4_stray_no_resp", n_resp, r0);
    exp_push(32'h4000_0000, 32'h0000_0100, 1'b1, 4'd9, fmodel(32'h4000_0000, 32'h8000_0100), 1'b0);
    drain("t4n");

    // reset while busy with two queued
    lat = 20;
    exp_push(32'h1111_1111, 32'h2222_2222, 1'b0, 4'd8, 32'h0, 1'b0);
    exp_push(32'h3333_3333, 32'h4444_4444, 1'b0, 4'd9, 32'h0, 1'b0);
    exp_push(32'h5555_5555, 32'h6666_6666, 1'b0, 4'd10, 32'h0, 1'b0);
    chk("t5_in_wait", 32'(busy && !fpu_en && !out_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check_reset("t5_rst");
    exp_q.delete();
    tick();
    tick();
    reset_n = 1'b1;
    r0 = n_resp;
    repeat (40) tick();
    chk("t5_no_stale_resp", n_resp, r0);
    chk("t5_idle_after", 32'(busy), 32'd0);
    lat = 7;
    exp_push(32'h0BAD_0000, 32'h0000_F00D, 1'b0, 4'd12, fmodel(32'h0BAD_0000, 32'h0000_F00D), 1'b0);
    drain("t5n");

    // random operands with random backpressure
    rand_lat = 1;
    r0 = n_resp;
    done = 0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          ra = $urandom;
          rb = (i % 10 == 0) ? 32'h0 : (i % 10 == 1) ? 32'h8000_0000 : $urandom;
          rs = 1'($urandom_range(0, 1));
          exp_push(ra, rb, rs, TAG_W'(i), fmodel(ra, exp_b(rb, rs)), 1'b0);
        end
        done = 1;
      end
      begin
        while (!done) begin
          out_ready = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    out_ready = 1'b1;
    drain("t6");
    chk("t6_resp_count", n_resp, r0 + 200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
